// File: rtl/arb_mux_n_pkg.sv
// Shared definitions for the arb_mux_n slice: selection-mode encoding and a
// constant clog2 used to size channel indices.
package arb_mux_n_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,  // lowest valid index wins
    MODE_RR    = 2'd1,  // round-robin from rr_ptr
    MODE_EXT   = 2'd2   // external index
  } mode_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// rr_arbiter: combinational grant selection for arb_mux_n.
// Ports:
//   req       in  N     per-channel request
//   ptr       in  SELW  round-robin start index
//   mode      in  2     selection mode (mode_e)
//   lock_q    in  1     grant is locked to lock_ch
//   lock_ch   in  SELW  locked channel
//   ext_sel   in  SELW  external channel index (MODE_EXT)
//   gnt_valid out 1     a channel is granted
//   gnt_idx   out SELW  granted channel index (0 when no grant)
module rr_arbiter
  import arb_mux_n_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned SELW = 3
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  mode_e           mode,
  input  logic            lock_q,
  input  logic [SELW-1:0] lock_ch,
  input  logic [SELW-1:0] ext_sel,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (lock_q) begin
      // A held lock overrides every mode; a locked channel that drops valid
      // simply produces no grant.
      for (int unsigned i = 0; i < N; i++) begin
        if (SELW'(i) == lock_ch && req[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SELW'(i);
        end
      end
    end else begin
      case (mode)
        MODE_FIXED: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (!gnt_valid && req[i]) begin
              gnt_valid = 1'b1;
              gnt_idx   = SELW'(i);
            end
          end
        end
        MODE_RR: begin
          // Two passes replace a modular search: first at/after ptr, then
          // wrap to the lowest valid index below ptr.
          for (int unsigned i = 0; i < N; i++) begin
            if (!gnt_valid && req[i] && SELW'(i) >= ptr) begin
              gnt_valid = 1'b1;
              gnt_idx   = SELW'(i);
            end
          end
          for (int unsigned i = 0; i < N; i++) begin
            if (!gnt_valid && req[i]) begin
              gnt_valid = 1'b1;
              gnt_idx   = SELW'(i);
            end
          end
        end
        MODE_EXT: begin
          // Compare-based match, so ext_sel >= N never indexes out of range.
          for (int unsigned i = 0; i < N; i++) begin
            if (SELW'(i) == ext_sel && req[i]) begin
              gnt_valid = 1'b1;
              gnt_idx   = SELW'(i);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N:1 arbitrated datapath mux with a registered valid/ready
// output stage and optional grant lock for multi-beat transfers.
// Ports:
//   clk       in  1     rising-edge clock
//   reset_n   in  1     asynchronous active-low reset
//   in_data   in  N*W   channel i = in_data[i*W +: W]
//   in_valid  in  N     per-channel request
//   in_ready  out N     one-hot (or zero) accept
//   ext_sel   in  SELW  channel index for MODE_EXT
//   lock      in  1     hold grant after this accepted beat
//   out_data  out W     registered selected data
//   out_sel   out SELW  registered source channel index
//   out_valid out 1     output register holds a beat
//   out_ready in  1     consumer accepts the beat
module arb_mux_n
  import arb_mux_n_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned N    = 8,
  parameter int unsigned SELW = clog2(N),
  parameter int unsigned MODE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [SELW-1:0] ext_sel,
  input  logic            lock,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam mode_e MODE_E = mode_e'(MODE[1:0]);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;

  logic            gnt_valid;
  logic [SELW-1:0] gnt_idx;
  logic            load;
  logic            xfer;

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .mode      (MODE_E),
    .lock_q    (lock_q),
    .lock_ch   (lock_ch_q),
    .ext_sel   (ext_sel),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    load = !out_valid_q || out_ready;
    // reset_n gates accept so no producer sees ready while reset is held.
    xfer = reset_n && gnt_valid && load;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = xfer && (gnt_idx == SELW'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    if (xfer) begin
      out_data_d  = in_data[gnt_idx*W +: W];
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      lock_d      = lock;
      if (lock) begin
        lock_ch_d = gnt_idx;
      end else begin
        // Explicit wrap so non-power-of-two N stays in range.
        rr_ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed scoreboard bench for arb_mux_n: round-robin, fixed-priority and
// external-select instances (N=8 and N=6) sharing one clock and data bus.
module tb_arb_mux_n;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] sel;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] in_data;
  logic        out_ready;
  logic        lock;
  logic [2:0]  ext_sel;

  logic [7:0] v_rr, v_fp, v_ex;
  logic [5:0] v_ex6;
  logic [7:0] rdy_rr, rdy_fp, rdy_ex;
  logic [5:0] rdy_ex6;
  logic [7:0] od_rr, od_fp, od_ex, od_ex6;
  logic [2:0] os_rr, os_fp, os_ex, os_ex6;
  logic       ov_rr, ov_fp, ov_ex, ov_ex6;

  beat_t q_rr[$], q_fp[$], q_ex[$], q_ex6[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_mux_n #(.W(8), .N(8), .SELW(3), .MODE(1)) u_rr (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(v_rr),
    .in_ready(rdy_rr), .ext_sel(ext_sel), .lock(lock), .out_data(od_rr),
    .out_sel(os_rr), .out_valid(ov_rr), .out_ready(out_ready));

  arb_mux_n #(.W(8), .N(8), .SELW(3), .MODE(0)) u_fp (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(v_fp),
    .in_ready(rdy_fp), .ext_sel(ext_sel), .lock(1'b0), .out_data(od_fp),
    .out_sel(os_fp), .out_valid(ov_fp), .out_ready(out_ready));

  arb_mux_n #(.W(8), .N(8), .SELW(3), .MODE(2)) u_ex (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(v_ex),
    .in_ready(rdy_ex), .ext_sel(ext_sel), .lock(1'b0), .out_data(od_ex),
    .out_sel(os_ex), .out_valid(ov_ex), .out_ready(out_ready));

  arb_mux_n #(.W(8), .N(6), .SELW(3), .MODE(2)) u_ex6 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[47:0]), .in_valid(v_ex6),
    .in_ready(rdy_ex6), .ext_sel(ext_sel), .lock(1'b0), .out_data(od_ex6),
    .out_sel(os_ex6), .out_valid(ov_ex6), .out_ready(out_ready));

  function automatic beat_t mk(input int unsigned ch);
    beat_t b;
    b.data = 8'(8'h10 + ch);
    b.sel  = 3'(ch);
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the negedge every beat the consumer takes this cycle is
  // checked against its queue head; returns #1 after the next posedge.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    if (ov_rr && out_ready) begin
      if (q_rr.size() == 0) check("rr_unexpected_beat", 32'(ov_rr), 0);
      else begin
        b = q_rr.pop_front();
        check("rr_data", 32'(od_rr), 32'(b.data));
        check("rr_sel", 32'(os_rr), 32'(b.sel));
      end
    end
    if (ov_fp && out_ready) begin
      if (q_fp.size() == 0) check("fp_unexpected_beat", 32'(ov_fp), 0);
      else begin
        b = q_fp.pop_front();
        check("fp_data", 32'(od_fp), 32'(b.data));
        check("fp_sel", 32'(os_fp), 32'(b.sel));
      end
    end
    if (ov_ex && out_ready) begin
      if (q_ex.size() == 0) check("ex_unexpected_beat", 32'(ov_ex), 0);
      else begin
        b = q_ex.pop_front();
        check("ex_data", 32'(od_ex), 32'(b.data));
        check("ex_sel", 32'(os_ex), 32'(b.sel));
      end
    end
    if (ov_ex6 && out_ready) begin
      if (q_ex6.size() == 0) check("ex6_unexpected_beat", 32'(ov_ex6), 0);
      else begin
        b = q_ex6.pop_front();
        check("ex6_data", 32'(od_ex6), 32'(b.data));
        check("ex6_sel", 32'(os_ex6), 32'(b.sel));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e;
    reset_n   = 1'b0;
    out_ready = 1'b1;
    lock      = 1'b0;
    ext_sel   = 3'd0;
    v_rr      = 8'hFF;
    v_fp      = 8'h00;
    v_ex      = 8'h00;
    v_ex6     = 6'h00;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);

    // Reset state; in_ready must stay low despite valid requests.
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(ov_rr), 0);
    check("rst_out_data", 32'(od_rr), 0);
    check("rst_out_sel", 32'(os_rr), 0);
    check("rst_in_ready", 32'(rdy_rr), 0);
    reset_n = 1'b1;
    #1;

    // 1: round-robin streaming, 0..7 then wrap to 0.
    for (int k = 0; k < 9; k++) begin
      e = 8'h01 << (k % 8);
      check("t1_in_ready", 32'(rdy_rr), 32'(e));
      q_rr.push_back(mk(k % 8));
      tick();
    end
    v_rr = 8'h00;
    tick();

    // 3: back-pressure after the first beat, then gapless resume.
    v_rr = 8'hFF;
    #1;
    check("t3_in_ready", 32'(rdy_rr), 32'h02);
    q_rr.push_back(mk(1));
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_bp_in_ready", 32'(rdy_rr), 0);
      check("t3_bp_valid", 32'(ov_rr), 1);
      check("t3_bp_data", 32'(od_rr), 32'h11);
      check("t3_bp_sel", 32'(os_rr), 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t3_rel_in_ready", 32'(rdy_rr), 32'h04);
    q_rr.push_back(mk(2));
    tick();
    check("t3_next_in_ready", 32'(rdy_rr), 32'h08);
    q_rr.push_back(mk(3));
    tick();
    v_rr = 8'h00;
    tick();
    check("t3_drain_valid", 32'(ov_rr), 0);
    check("t3_hold_data", 32'(od_rr), 32'h13);

    // 4: lock on channel 3 with channel 4 competing.
    v_rr = 8'h04;
    #1;
    check("t4_pre_in_ready", 32'(rdy_rr), 32'h04);
    q_rr.push_back(mk(2));
    tick();
    v_rr = 8'h18;
    lock = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t4_lock_in_ready", 32'(rdy_rr), 32'h08);
      q_rr.push_back(mk(3));
      tick();
    end
    v_rr = 8'h10;
    #1;
    check("t4_lock_stall", 32'(rdy_rr), 0);
    tick();
    v_rr = 8'h18;
    #1;
    check("t4_lock3_in_ready", 32'(rdy_rr), 32'h08);
    q_rr.push_back(mk(3));
    tick();
    lock = 1'b0;
    #1;
    check("t4_last_in_ready", 32'(rdy_rr), 32'h08);
    q_rr.push_back(mk(3));
    tick();
    check("t4_after_in_ready", 32'(rdy_rr), 32'h10);
    q_rr.push_back(mk(4));
    tick();
    v_rr = 8'h00;
    tick();

    // 6: reset with a held beat and an active lock.
    v_rr = 8'h80;
    lock = 1'b1;
    #1;
    check("t6_in_ready", 32'(rdy_rr), 32'h80);
    out_ready = 1'b0;
    tick();
    check("t6_held_valid", 32'(ov_rr), 1);
    check("t6_held_sel", 32'(os_rr), 7);
    v_rr = 8'h81;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(ov_rr), 0);
    check("t6_rst_in_ready", 32'(rdy_rr), 0);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    lock      = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t6_post_in_ready", 32'(rdy_rr), 32'h01);
    q_rr.push_back(mk(0));
    tick();
    v_rr = 8'h00;
    tick();

    // 2: fixed priority, channel 2 always wins over 5 and 7.
    v_fp = 8'b1010_0100;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t2_in_ready", 32'(rdy_fp), 32'h04);
      q_fp.push_back(mk(2));
      tick();
    end
    v_fp = 8'h00;
    tick();

    // 5: external select, invalid target, valid target, out-of-range index.
    v_ex    = 8'b1101_1111;
    ext_sel = 3'd5;
    #1;
    check("t5_invalid_in_ready", 32'(rdy_ex), 0);
    tick();
    check("t5_invalid_valid", 32'(ov_ex), 0);
    ext_sel = 3'd6;
    #1;
    check("t5_sel6_in_ready", 32'(rdy_ex), 32'h40);
    q_ex.push_back(mk(6));
    tick();
    v_ex = 8'h00;
    tick();
    v_ex6   = 6'h3F;
    ext_sel = 3'd7;
    #1;
    check("t5_range_in_ready", 32'(rdy_ex6), 0);
    tick();
    check("t5_range_valid", 32'(ov_ex6), 0);
    ext_sel = 3'd5;
    #1;
    check("t5_top_in_ready", 32'(rdy_ex6), 32'h20);
    q_ex6.push_back(mk(5));
    tick();
    v_ex6 = 6'h00;
    tick();

    tick();
    check("rr_q_empty", 32'(q_rr.size()), 0);
    check("fp_q_empty", 32'(q_fp.size()), 0);
    check("ex_q_empty", 32'(q_ex.size()), 0);
    check("ex6_q_empty", 32'(q_ex6.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
